// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_queue
// Description : Issue stage in front of the ALU. It buffers operand/command
//               words from a valid/ready producer in a small FIFO and issues
//               one word per slot with CE/INP_VALID. It stalls for multiply
//               latency and pulses RES_EXP when an ALU result is due.
// Options     : define ALU_ISSUE_CNT_EN to build the 16-bit issued-op counter;
//               with the macro undefined, ISSUE_CNT is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_queue #(
    parameter int DW        = 8,
    parameter int CW        = 4,
    parameter int DEPTH     = 4,
    parameter int ALU_LAT   = 1,
    parameter int MUL_LAT   = 2,
    parameter int MUL_CMD_A = 9,
    parameter int MUL_CMD_B = 10
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [DW-1:0]          IN_OPA,
    input  logic [DW-1:0]          IN_OPB,
    input  logic [CW-1:0]          IN_CMD,
    input  logic                   IN_MODE,
    input  logic                   IN_CIN,
    input  logic [1:0]             IN_INP_VALID,
    input  logic                   HOLD,
    input  logic                   FLUSH,
    output logic [DW-1:0]          OPA,
    output logic [DW-1:0]          OPB,
    output logic [CW-1:0]          CMD,
    output logic                   MODE,
    output logic                   CIN,
    output logic [1:0]             INP_VALID,
    output logic                   CE,
    output logic                   RES_EXP,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic [15:0]            ISSUE_CNT
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNTW  = AW + 1;
    // The wait counter only has to hold MUL_LAT-2 (extra CE cycles minus one).
    localparam int WAITW = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;

    localparam logic [CNTW-1:0]  FULL_CNT  = CNTW'(DEPTH);
    localparam logic [CW-1:0]    MUL_A     = CW'(MUL_CMD_A);
    localparam logic [CW-1:0]    MUL_B     = CW'(MUL_CMD_B);
    localparam logic [WAITW-1:0] WAIT_INIT = WAITW'(MUL_LAT - 2);

    typedef struct packed {
        logic [DW-1:0] opa;
        logic [DW-1:0] opb;
        logic [CW-1:0] cmd;
        logic          mode;
        logic          cin;
        logic [1:0]    iv;
    } word_t;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_MUL_WAIT = 1'b1
    } state_t;

    // FIFO state
    word_t           mem_q [DEPTH];
    word_t           mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            ready_q, ready_d;

    // Issue FSM and registered ALU-facing outputs
    state_t          state_q, state_d;
    logic [WAITW-1:0] wait_q, wait_d;
    word_t           out_q, out_d;
    logic            ce_q, ce_d;
    logic [1:0]      inp_valid_q, inp_valid_d;

    // Result-due pipeline
    logic [MUL_LAT-1:0] res_sr_q, res_sr_d;
    logic               res_exp_q, res_exp_d;

    word_t in_word;
    word_t head;
    logic  head_is_mul;
    logic  fifo_empty;
    logic  do_push;
    logic  do_issue;

    assign in_word     = {IN_OPA, IN_OPB, IN_CMD, IN_MODE, IN_CIN, IN_INP_VALID};
    assign head        = mem_q[rd_ptr_q];
    assign head_is_mul = head.mode && ((head.cmd == MUL_A) || (head.cmd == MUL_B));
    assign fifo_empty  = (count_q == '0);

    // Readiness comes from the registered full flag, so a pop while full never
    // admits a push in the same cycle. FLUSH beats both push and issue.
    assign do_push  = IN_VALID && ready_q && !FLUSH;
    assign do_issue = (state_q == S_IDLE) && !fifo_empty && !HOLD && !FLUSH;

    // FIFO write/read pointers, occupancy and next-cycle readiness
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = in_word;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_issue) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_issue})
                2'b10:   count_d = count_q + CNTW'(1);
                2'b01:   count_d = count_q - CNTW'(1);
                default: count_d = count_q;
            endcase
        end
        ready_d = (count_d != FULL_CNT);
    end

    // Issue FSM: loads the head word on issue, holds CE through multiply wait
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        out_d       = out_q;
        ce_d        = 1'b0;
        inp_valid_d = 2'b00;
        if (FLUSH) begin
            state_d = S_IDLE;
            wait_d  = '0;
        end else if (do_issue) begin
            out_d       = head;
            ce_d        = 1'b1;
            inp_valid_d = head.iv;
            if (head_is_mul) begin
                state_d = S_MUL_WAIT;
                wait_d  = WAIT_INIT;
            end
        end else if (state_q == S_MUL_WAIT) begin
            // Operands stay put and CE stays high while the multiplier works.
            ce_d        = 1'b1;
            inp_valid_d = out_q.iv;
            if (wait_q == '0) begin
                state_d = S_IDLE;
            end else begin
                wait_d = wait_q - WAITW'(1);
            end
        end
    end

    // Result-due shift register: an issue drops a token that reaches RES_EXP
    // exactly ALU_LAT or MUL_LAT cycles after the issue cycle.
    always_comb begin
        res_sr_d  = res_sr_q >> 1;
        res_exp_d = res_sr_q[0];
        if (FLUSH) begin
            res_sr_d  = '0;
            res_exp_d = 1'b0;
        end else if (do_issue) begin
            if (head_is_mul) begin
                res_sr_d[MUL_LAT-1] = 1'b1;
            end else begin
                res_sr_d[ALU_LAT-1] = 1'b1;
            end
        end
    end

    // State registers; reset returns every output to zero immediately
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b0;
            state_q     <= S_IDLE;
            wait_q      <= '0;
            out_q       <= '0;
            ce_q        <= 1'b0;
            inp_valid_q <= 2'b00;
            res_sr_q    <= '0;
            res_exp_q   <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ready_q     <= ready_d;
            state_q     <= state_d;
            wait_q      <= wait_d;
            out_q       <= out_d;
            ce_q        <= ce_d;
            inp_valid_q <= inp_valid_d;
            res_sr_q    <= res_sr_d;
            res_exp_q   <= res_exp_d;
        end
    end

`ifdef ALU_ISSUE_CNT_EN
    logic [15:0] issue_cnt_q, issue_cnt_d;

    // Issued-op counter, wraps naturally at 16 bits
    always_comb begin
        issue_cnt_d = issue_cnt_q;
        if (FLUSH) begin
            issue_cnt_d = '0;
        end else if (do_issue) begin
            issue_cnt_d = issue_cnt_q + 16'd1;
        end
    end

    // Issued-op counter register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            issue_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign ISSUE_CNT = issue_cnt_q;
`else
    assign ISSUE_CNT = 16'h0000;
`endif

    assign IN_READY  = ready_q;
    assign COUNT     = count_q;
    assign OPA       = out_q.opa;
    assign OPB       = out_q.opb;
    assign CMD       = out_q.cmd;
    assign MODE      = out_q.mode;
    assign CIN       = out_q.cin;
    assign INP_VALID = inp_valid_q;
    assign CE        = ce_q;
    assign RES_EXP   = res_exp_q;

endmodule
`default_nettype wire
